hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard responder for the five-stage CPU. It consumes the controller's hazard interface (RegWriteM, MemtoRegE, PCWrPendingF, BranchTakenE, PCSrcW) plus register addresses from the datapath. It returns the operand forwarding selects, per-stage stall and flush strobes (including FlushE back to the controller), and the handshake for multi-cycle DIV/MOD execution. It sits beside the controller and datapath at the top of the CPU.

## Interface
- DIV_LATENCY, 4, total cycles a DIV/MOD occupies Execute (legal 1..15)
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high; clears all internal state
- RA1D, RA2D  in  4  source registers of the instruction in Decode
- RA1E, RA2E  in  4  source registers of the instruction in Execute
- WA3E, WA3M, WA3W  in  4  destination registers in Execute, Memory and Writeback
- RegWriteM, RegWriteW  in  1  register write pending in Memory / Writeback
- MemtoRegE  in  1  Execute instruction is a load
- PCWrPendingF  in  1  PC write in flight in Decode, Execute or Memory
- BranchTakenE  in  1  taken branch resolved in Execute
- PCSrcW  in  1  PC write retiring in Writeback
- ValidE  in  1  Execute holds a live instruction, not a bubble
- ALUControlE  in  3  Execute ALU op; 011 = DIV, 100 = MOD
- ForwardAE, ForwardBE  out  2  operand select: 00 = register file, 01 = Writeback result, 10 = Memory ALU result
- StallF, StallD, StallE  out  1  hold the Fetch/Decode/Execute registers
- FlushD, FlushE, FlushM  out  1  clear the Decode/Execute/Memory registers
- DivStartE  out  1  divider captures its operands this cycle
- DivDoneE  out  1  divider result is valid this cycle
- StallCount, FlushCount  out  16  performance counters (see Configuration)

## Operation
- Forwarding, shown for A (B is identical using RA2E):
  - ForwardAE = 10 if RegWriteM and RA1E==WA3M.
  - Else 01 if RegWriteW and RA1E==WA3W.
  - Else 00.
  - Memory has priority over Writeback.
- Load-use stall: LdStall = MemtoRegE & ((RA1D==WA3E) | (RA2D==WA3E)).
- Multi-cycle op: DivReq = ValidE & (ALUControlE==011 | ALUControlE==100).
- Counter: 4-bit cnt tracks cycles spent in Execute.
  - DivStall = DivReq & (cnt != DIV_LATENCY-1).
  - When DivStall=1, cnt increments on each edge. Otherwise it returns to 0.
- Handshake:
  - DivStartE = DivReq & cnt==0. The ALU latches its forwarded operands on this edge, because the forwarding sources retire while Execute is held.
  - DivDoneE = DivReq & cnt==DIV_LATENCY-1.
- Outputs:
  - StallF = LdStall | PCWrPendingF | DivStall
  - StallD = LdStall | DivStall
  - StallE = DivStall
  - FlushM = DivStall (bubbles into Memory)
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE
  - FlushE = (LdStall | BranchTakenE) & ~DivStall
- Flush dominates stall in every pipeline register.
- LdStall and DivStall are mutually exclusive, since a load is never a DIV/MOD. BranchTakenE never coincides with DivReq.

## Timing
- Forwarding and all stall/flush outputs are combinational from the current inputs and cnt. Zero latency.
- A DIV/MOD enters Execute at cycle t:
  - Stalls are asserted in cycles t..t+DIV_LATENCY-2.
  - DivStartE is high at t. DivDoneE is high at t+DIV_LATENCY-1.
  - The op leaves Execute on the edge ending t+DIV_LATENCY-1.
- DIV_LATENCY=1: no stall. DivStartE and DivDoneE are both high in cycle t.
- Back-to-back DIVs: cnt returns to 0 on the departure edge. The next DIV starts its own full sequence.
- ValidE falling mid-count: DivStall drops and cnt clears on the next edge.
- Reset (asynchronous, mid-operation included):
  - cnt = 0 and the counters = 0 immediately.
  - With reset held and inputs idle: all outputs are 0 and ForwardAE = ForwardBE = 00.

## Configuration
- HAZARD_PERF_EN defined:
  - StallCount increments on every cycle with StallD=1.
  - FlushCount increments on every cycle with FlushD|FlushE=1.
  - Both are 16-bit, saturate at 0xFFFF and clear on reset.
- HAZARD_PERF_EN undefined: no counter flops. StallCount and FlushCount are tied to 0.

## Test plan
- Forwarding priority: RA1E=3, WA3M=3, WA3W=3, RegWriteM=RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. Set RA1E=4 -> 00.
- Load-use: MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for exactly one cycle, FlushD=0.
- DIV with DIV_LATENCY=4:
  - DIV held in Execute from cycle t -> StallF/D/E and FlushM high in t..t+2, DivStartE at t, DivDoneE at t+3.
  - Then all stalls are 0. FlushE stays 0 throughout.
- Branch: BranchTakenE=1 -> FlushD=FlushE=1, StallF=0. PCWrPendingF=1 -> StallF=FlushD=1 while asserted.
- Reset in the middle of a DIV (cnt=2) -> all outputs and counters are 0 immediately. The same DIV re-presented after reset gets a full 4-cycle sequence.
- HAZARD_PERF_EN: 70000 stall cycles -> StallCount=0xFFFF. Without the macro -> StallCount stays 0.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding, load-use/DIV stalls, flushes and divider handshake for the 5-stage pipe.
// Optional HAZARD_PERF_EN adds saturating StallCount/FlushCount performance counters.
module hazard_unit #(
  parameter int DIV_LATENCY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCWrPendingF,
  input  logic       BranchTakenE,
  input  logic       PCSrcW,
  input  logic       ValidE,
  input  logic [2:0] ALUControlE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       DivStartE,
  output logic       DivDoneE,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
);
  logic [3:0] cnt;
  logic       ldStall, divReq, divLast, divStall;
  always_comb begin
    ForwardAE = (RegWriteM && RA1E == WA3M) ? 2'b10 : (RegWriteW && RA1E == WA3W) ? 2'b01 : 2'b00;
    ForwardBE = (RegWriteM && RA2E == WA3M) ? 2'b10 : (RegWriteW && RA2E == WA3W) ? 2'b01 : 2'b00;
    ldStall   = MemtoRegE && (RA1D == WA3E || RA2D == WA3E);
    divReq    = ValidE && (ALUControlE == 3'b011 || ALUControlE == 3'b100);
    divLast   = cnt == 4'(DIV_LATENCY - 1);
    divStall  = divReq && !divLast;
    DivStartE = divReq && cnt == 4'd0;
    DivDoneE  = divReq && divLast;
    StallF    = ldStall || PCWrPendingF || divStall;
    StallD    = ldStall || divStall;
    StallE    = divStall;
    FlushM    = divStall;
    FlushD    = PCWrPendingF || PCSrcW || BranchTakenE;
    FlushE    = (ldStall || BranchTakenE) && !divStall;
  end
  // cnt counts cycles the op has sat in Execute; it falls back to 0 on the departure edge
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= 4'd0;
    else       cnt <= divStall ? cnt + 4'd1 : 4'd0;
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      StallCount <= 16'd0;
      FlushCount <= 16'd0;
    end else begin
      if (StallD && StallCount != 16'hFFFF) StallCount <= StallCount + 16'd1;
      if ((FlushD || FlushE) && FlushCount != 16'hFFFF) FlushCount <= FlushCount + 16'd1;
    end
`else
  assign StallCount = 16'd0;
  assign FlushCount = 16'd0;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed checks of forwarding, stalls, flushes and the DIV handshake.
module tb_hazard_unit;
  logic clk = 1'b0, reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, BranchTakenE, PCSrcW, ValidE;
  logic [2:0] ALUControlE;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, DivStartE, DivDoneE;
  logic [15:0] StallCount, FlushCount;
  logic [7:0] ctl;
  int nCmp = 0, nErr = 0;

  hazard_unit #(.DIV_LATENCY(4)) dut (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCWrPendingF(PCWrPendingF), .BranchTakenE(BranchTakenE),
    .PCSrcW(PCSrcW), .ValidE(ValidE), .ALUControlE(ALUControlE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .DivStartE(DivStartE), .DivDoneE(DivDoneE), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;
  // {StallF,StallD,StallE,FlushD,FlushE,FlushM,DivStartE,DivDoneE}
  assign ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM, DivStartE, DivDoneE};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, BranchTakenE, PCSrcW, ValidE} = '0;
    ALUControlE = 3'b000;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #12;
    chk("reset_ctl", 16'(ctl), 16'h00);
    chk("reset_fwd", {12'd0, ForwardAE, ForwardBE}, 16'h0);
    chk("reset_scnt", StallCount, 16'h0);
    chk("reset_fcnt", FlushCount, 16'h0);
    reset = 1'b0;
    tick();
    // forwarding priority
    RA1E = 4'd3; WA3M = 4'd3; WA3W = 4'd3; RegWriteM = 1'b1; RegWriteW = 1'b1; RA2E = 4'd0;
    #1 chk("fwdA_mem", 16'(ForwardAE), 16'h2);
    chk("fwdB_none", 16'(ForwardBE), 16'h0);
    RegWriteM = 1'b0;
    #1 chk("fwdA_wb", 16'(ForwardAE), 16'h1);
    RA1E = 4'd4;
    #1 chk("fwdA_none", 16'(ForwardAE), 16'h0);
    RA2E = 4'd3;
    #1 chk("fwdB_wb", 16'(ForwardBE), 16'h1);
    RegWriteM = 1'b1;
    #1 chk("fwdB_mem", 16'(ForwardBE), 16'h2);
    idle();
    tick();
    // load-use
    MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; RA1D = 4'd1;
    #1 chk("lduse_b", 16'(ctl), 16'hC8);
    tick();
    MemtoRegE = 1'b0;
    #1 chk("lduse_gone", 16'(ctl), 16'h00);
    MemtoRegE = 1'b1; RA1D = 4'd5; RA2D = 4'd2;
    #1 chk("lduse_a", 16'(ctl), 16'hC8);
    RA1D = 4'd6;
    #1 chk("lduse_nomatch", 16'(ctl), 16'h00);
    idle();
    // branch / PC write
    BranchTakenE = 1'b1;
    #1 chk("branch", 16'(ctl), 16'h18);
    BranchTakenE = 1'b0; PCWrPendingF = 1'b1;
    #1 chk("pcwr", 16'(ctl), 16'h90);
    PCWrPendingF = 1'b0; PCSrcW = 1'b1;
    #1 chk("pcsrcw", 16'(ctl), 16'h10);
    idle();
    ALUControlE = 3'b011;
    #1 chk("div_invalid", 16'(ctl), 16'h00);
    ValidE = 1'b1; ALUControlE = 3'b010;
    #1 chk("alu_nodiv", 16'(ctl), 16'h00);
    tick();
    // DIV, latency 4
    ALUControlE = 3'b011;
    #1 chk("div_t0", 16'(ctl), 16'hE6);
    tick(); chk("div_t1", 16'(ctl), 16'hE4);
    tick(); chk("div_t2", 16'(ctl), 16'hE4);
    tick(); chk("div_t3", 16'(ctl), 16'h01);
    // back-to-back MOD
    ALUControlE = 3'b100;
    tick(); chk("mod_t0", 16'(ctl), 16'hE6);
    tick(); chk("mod_t1", 16'(ctl), 16'hE4);
    ValidE = 1'b0;
    #1 chk("validE_drop", 16'(ctl), 16'h00);
    tick();
    ValidE = 1'b1; ALUControlE = 3'b011;
    #1 chk("div_restart", 16'(ctl), 16'hE6);
    tick(); tick();
    chk("div_cnt2", 16'(ctl), 16'hE4);
    // async reset mid-DIV: cnt clears at once, so DivStartE reappears
    reset = 1'b1;
    #1 chk("rst_async_cnt", 16'(ctl), 16'hE6);
    idle();
    #1 chk("rst_idle_ctl", 16'(ctl), 16'h00);
    chk("rst_idle_fwd", {12'd0, ForwardAE, ForwardBE}, 16'h0);
    chk("rst_scnt", StallCount, 16'h0);
    #1 reset = 1'b0;
    tick();
    ValidE = 1'b1; ALUControlE = 3'b011;
    #1 chk("rediv_t0", 16'(ctl), 16'hE6);
    tick(); chk("rediv_t1", 16'(ctl), 16'hE4);
    tick(); chk("rediv_t2", 16'(ctl), 16'hE4);
    tick(); chk("rediv_t3", 16'(ctl), 16'h01);
    ValidE = 1'b0;
    tick();
    chk("after_div", 16'(ctl), 16'h00);
`ifdef HAZARD_PERF_EN
    reset = 1'b1;
    #1 reset = 1'b0;
    MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
    repeat (3) tick();
    chk("perf_scnt3", StallCount, 16'd3);
    chk("perf_fcnt3", FlushCount, 16'd3);
    repeat (70000) tick();
    chk("perf_scnt_sat", StallCount, 16'hFFFF);
    chk("perf_fcnt_sat", FlushCount, 16'hFFFF);
`else
    chk("noperf_scnt", StallCount, 16'h0);
    chk("noperf_fcnt", FlushCount, 16'h0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
